// File: rtl/mips_defs.sv
// Shared definitions for the MIPS core: XALU op encodings, datapath widths
// and the multiply/divide unit state type.
package mips_defs;

  localparam int WORD  = 32;
  localparam int DWORD = 64;

  // XALUOp_E encodings
  localparam logic [2:0] XOP_MULT  = 3'b000;
  localparam logic [2:0] XOP_MULTU = 3'b001;
  localparam logic [2:0] XOP_DIV   = 3'b010;
  localparam logic [2:0] XOP_DIVU  = 3'b011;
  localparam logic [2:0] XOP_MTHI  = 3'b100;
  localparam logic [2:0] XOP_MTLO  = 3'b101;
  localparam logic [2:0] XOP_MADD  = 3'b110;
  localparam logic [2:0] XOP_MSUB  = 3'b111;

  typedef enum logic {
    XS_IDLE = 1'b0,
    XS_RUN  = 1'b1
  } xalu_state_t;

endpackage

// File: rtl/xalu_divider.sv
// Combinational signed/unsigned 32-bit divider for the XALU.
// Divide by zero yields quotient all-ones and remainder equal to the dividend.
// The signed overflow case 0x80000000 / -1 falls out of the magnitude method
// as quotient 0x80000000, remainder 0.
module xalu_divider
  import mips_defs::*;
(
  input  logic [WORD-1:0] i_a,
  input  logic [WORD-1:0] i_b,
  input  logic            i_signed,
  output logic [WORD-1:0] o_q,
  output logic [WORD-1:0] o_r
);

  logic            w_neg_a;
  logic            w_neg_b;
  logic [WORD-1:0] w_mag_a;
  logic [WORD-1:0] w_mag_b;
  logic [WORD-1:0] w_uq;
  logic [WORD-1:0] w_ur;

  // Divide magnitudes unsigned, then restore signs: quotient truncates toward
  // zero, remainder takes the sign of the dividend.
  always_comb begin
    // NOTE: every output of a combinational block gets a value on every path
    // (defaults first) so no latch is inferred.
    w_neg_a = i_signed & i_a[WORD-1];
    w_neg_b = i_signed & i_b[WORD-1];
    w_mag_a = w_neg_a ? (~i_a + 1'b1) : i_a;
    w_mag_b = w_neg_b ? (~i_b + 1'b1) : i_b;
    w_uq    = '0;
    w_ur    = '0;
    o_q     = '1;
    o_r     = i_a;
    if (i_b != '0) begin
      w_uq = w_mag_a / w_mag_b;
      w_ur = w_mag_a % w_mag_b;
      o_q  = (w_neg_a ^ w_neg_b) ? (~w_uq + 1'b1) : w_uq;
      o_r  = w_neg_a ? (~w_ur + 1'b1) : w_ur;
    end
  end

endmodule

// File: rtl/xalu_muldiv.sv
// Multi-cycle multiply/divide unit with HI/LO registers.
// The result is computed at start, parked in pend_hi/pend_lo and committed to
// HI/LO after a fixed latency, so no partial result is ever visible.
// Optional feature: define XALU_MADD_EN to enable MADD/MSUB (ops 110/111);
// otherwise those ops are no-ops.
module xalu_muldiv
  import mips_defs::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [WORD-1:0] a,
  input  logic [WORD-1:0] b,
  output logic            busy,
  output logic [WORD-1:0] hi,
  output logic [WORD-1:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  xalu_state_t      r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic [WORD-1:0]  r_hi;
  logic [WORD-1:0]  r_lo;
  logic [WORD-1:0]  r_pend_hi;
  logic [WORD-1:0]  r_pend_lo;

  logic [DWORD-1:0] w_prod_s;
  logic [DWORD-1:0] w_prod_u;
  logic [WORD-1:0]  w_div_q;
  logic [WORD-1:0]  w_div_r;
  logic [DWORD-1:0] w_res;
  logic             w_long;
  logic [CNT_W-1:0] w_cycles;

  // Operands are widened explicitly so the products are full 64-bit.
  assign w_prod_s = $signed({{WORD{a[WORD-1]}}, a}) * $signed({{WORD{b[WORD-1]}}, b});
  assign w_prod_u = {{WORD{1'b0}}, a} * {{WORD{1'b0}}, b};

  xalu_divider u_divider (
    .i_a      (a),
    .i_b      (b),
    .i_signed (op == XOP_DIV),
    .o_q      (w_div_q),
    .o_r      (w_div_r)
  );

  // Decode op into the pending {hi,lo} result and the latency to apply.
  always_comb begin
    w_res    = '0;
    w_long   = 1'b0;
    w_cycles = CNT_W'(MULT_CYCLES);
    case (op)
      XOP_MULT:  begin w_res = w_prod_s; w_long = 1'b1; end
      XOP_MULTU: begin w_res = w_prod_u; w_long = 1'b1; end
      XOP_DIV, XOP_DIVU: begin
        w_res    = {w_div_r, w_div_q};
        w_long   = 1'b1;
        w_cycles = CNT_W'(DIV_CYCLES);
      end
`ifdef XALU_MADD_EN
      // Accumulator is sampled here; safe because start is refused while busy.
      XOP_MADD:  begin w_res = {r_hi, r_lo} + w_prod_s; w_long = 1'b1; end
      XOP_MSUB:  begin w_res = {r_hi, r_lo} - w_prod_s; w_long = 1'b1; end
`endif
      default: ;
    endcase
  end

  // IDLE/RUN controller, latency counter and HI/LO registers.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values; reset clears everything, pending results too,
    // so an aborted operation can never leak into HI/LO.
    if (!reset) begin
      r_state   <= XS_IDLE;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_pend_hi <= '0;
      r_pend_lo <= '0;
    end else begin
      case (r_state)
        XS_IDLE: begin
          if (start) begin
            if (w_long) begin
              r_pend_hi <= w_res[DWORD-1:WORD];
              r_pend_lo <= w_res[WORD-1:0];
              r_cnt     <= w_cycles;
              r_busy    <= 1'b1;
              r_state   <= XS_RUN;
            end else if (op == XOP_MTHI) begin
              r_hi <= a;
            end else if (op == XOP_MTLO) begin
              r_lo <= a;
            end
          end
        end
        XS_RUN: begin
          // start is ignored here; the hazard unit must not issue it.
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == CNT_W'(1)) begin
            r_hi    <= r_pend_hi;
            r_lo    <= r_pend_lo;
            r_busy  <= 1'b0;
            r_state <= XS_IDLE;
          end
        end
        default: r_state <= XS_IDLE;
      endcase
    end
  end

  assign busy = r_busy;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_xalu_muldiv.sv
// Self-checking bench for xalu_muldiv. Expected HI/LO values are pushed to a
// scoreboard when an op is issued and popped when the unit finishes.
// Covers MADD/MSUB when compiled with XALU_MADD_EN, the no-op case otherwise.
module tb_xalu_muldiv;
  import mips_defs::*;

  localparam int MC = 5;
  localparam int DC = 10;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  logic        clk   = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op    = '0;
  logic [31:0] a     = '0;
  logic [31:0] b     = '0;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  exp_t        sb[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] m_hi  = '0;
  logic [31:0] m_lo  = '0;

  always #5 clk = ~clk;

  xalu_muldiv #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Independent reference for the arithmetic ops; returns {hi,lo}.
  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] x,
                                        input logic [31:0] y);
    logic signed [31:0] sx, sy;
    longint             p;
    sx = x;
    sy = y;
    model = '0;
    case (o)
      XOP_MULT:  begin p = longint'(sx) * longint'(sy); model = p; end
      XOP_MULTU: model = {32'd0, x} * {32'd0, y};
      XOP_DIV: begin
        if (y == 0)                                 model = {x, 32'hFFFF_FFFF};
        else if (x == 32'h8000_0000 && y == '1)     model = {32'h0, 32'h8000_0000};
        else                                        model = {32'(sx % sy), 32'(sx / sy)};
      end
      XOP_DIVU: begin
        if (y == 0) model = {x, 32'hFFFF_FFFF};
        else        model = {x % y, x / y};
      end
      default: model = {m_hi, m_lo};
    endcase
  endfunction

  task automatic pop_and_check(input string tag);
    exp_t e;
    e = sb.pop_front();
    check({tag, "_hi"}, {32'd0, hi}, {32'd0, e.hi});
    check({tag, "_lo"}, {32'd0, lo}, {32'd0, e.lo});
    m_hi = e.hi;
    m_lo = e.lo;
  endtask

  // Issue a multi-cycle op, count busy cycles, verify HI/LO hold until commit.
  // With inject set, an MTLO is presented while busy and must be ignored.
  task automatic run_long(input string tag, input logic [2:0] o, input logic [31:0] x,
                          input logic [31:0] y, input int cyc, input logic [31:0] eh,
                          input logic [31:0] el, input bit inject);
    int nb;
    bit done;
    sb.push_back('{hi: eh, lo: el});
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
    if (inject) begin
      start = 1'b1; op = XOP_MTLO; a = 32'hDEAD_BEEF;
    end
    nb   = 0;
    done = 1'b0;
    for (int i = 0; i < 64 && !done; i++) begin
      if (i > 0) @(negedge clk);
      if (i == 1) start = 1'b0;
      if (busy) begin
        nb++;
        check({tag, "_hold"}, {hi, lo}, {m_hi, m_lo});
      end else begin
        done = 1'b1;
      end
    end
    start = 1'b0;
    if (!done) check({tag, "_timeout"}, {63'd0, busy}, 64'd0);
    check({tag, "_busy_cycles"}, 64'(nb), 64'(cyc));
    pop_and_check(tag);
  endtask

  // Issue MTHI/MTLO: visible after one edge, busy never rises.
  task automatic run_mt(input string tag, input logic [2:0] o, input logic [31:0] x);
    if (o == XOP_MTHI) sb.push_back('{hi: x, lo: m_lo});
    else               sb.push_back('{hi: m_hi, lo: x});
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = 32'h5555_5555;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_busy"}, {63'd0, busy}, 64'd0);
    pop_and_check(tag);
  endtask

  initial begin
    logic [2:0]  ro;
    logic [31:0] rx, ry;
    logic [63:0] rexp;

    // Reset state
    repeat (2) @(negedge clk);
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_hilo", {hi, lo}, 64'd0);
    reset = 1'b1;

    // 1. MULT -3 * 7
    run_long("mult_neg", XOP_MULT, 32'hFFFF_FFFD, 32'd7, MC, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
    // 2. DIVU / DIV
    run_long("divu", XOP_DIVU, 32'd100, 32'd7, DC, 32'd2, 32'd14, 1'b0);
    run_long("div_neg", XOP_DIV, 32'hFFFF_FFF9, 32'd2, DC, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    // 3. Boundaries
    run_long("div_by0", XOP_DIV, 32'd5, 32'd0, DC, 32'd5, 32'hFFFF_FFFF, 1'b0);
    run_long("div_ovf", XOP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, DC, 32'd0, 32'h8000_0000, 1'b0);
    run_long("divu_by0", XOP_DIVU, 32'h0000_1234, 32'd0, DC, 32'h0000_1234, 32'hFFFF_FFFF, 1'b0);
    // 4. MTHI, then MULT with a refused MTLO while busy
    run_mt("mthi", XOP_MTHI, 32'h0000_1234);
    run_long("mult_inject", XOP_MULT, 32'd6, 32'd7, MC, 32'd0, 32'd42, 1'b1);

    // Random arithmetic against the reference model
    for (int i = 0; i < 8; i++) begin
      ro   = 3'($urandom_range(0, 3));
      rx   = $urandom;
      ry   = (i == 3) ? 32'd0 : ((i % 2 == 0) ? $urandom : 32'($urandom_range(1, 300)));
      rexp = model(ro, rx, ry);
      run_long($sformatf("rand%0d", i), ro, rx, ry, (ro < 3'd2) ? MC : DC,
               rexp[63:32], rexp[31:0], 1'b0);
    end

    // 5. Async reset in the middle of a DIV
    run_long("pre_rst", XOP_MULTU, 32'h0001_0001, 32'h0003_0003, MC, 32'h0000_0003,
             32'h0006_0003, 1'b0);
    @(negedge clk);
    start = 1'b1; op = XOP_DIV; a = 32'd100; b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_pre_busy", {63'd0, busy}, 64'd1);
    #2 reset = 1'b0;
    #1;
    check("rst_async_busy", {63'd0, busy}, 64'd0);
    check("rst_async_hilo", {hi, lo}, 64'd0);
    m_hi = '0;
    m_lo = '0;
    @(negedge clk);
    reset = 1'b1;
    run_long("multu_after_rst", XOP_MULTU, 32'hFFFF_FFFF, 32'd2, MC, 32'd1, 32'hFFFF_FFFE, 1'b0);

    // 6. MADD/MSUB or their no-op behaviour
`ifdef XALU_MADD_EN
    run_mt("mthi0", XOP_MTHI, 32'd0);
    run_mt("mtlo_ones", XOP_MTLO, 32'hFFFF_FFFF);
    run_long("madd", XOP_MADD, 32'd1, 32'd1, MC, 32'd1, 32'd0, 1'b0);
    run_long("msub", XOP_MSUB, 32'd1, 32'd1, MC, 32'd0, 32'hFFFF_FFFF, 1'b0);
`else
    @(negedge clk);
    start = 1'b1; op = XOP_MADD; a = 32'd3; b = 32'd4;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("madd_nop_busy", {63'd0, busy}, 64'd0);
      @(negedge clk);
    end
    check("madd_nop_hilo", {hi, lo}, {m_hi, m_lo});
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
